// File: rtl/axil_memory_responder.sv
// AXI4-Lite slave backed by a word-addressed memory array, with concurrent read and
// write engines and a programmable response delay.
module axil_memory_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_WORDS = 4096,
  parameter int          LATENCY   = 2
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic [31:0] s_axil_araddr,
  input  logic        s_axil_arvalid,
  output logic        s_axil_arready,
  output logic [31:0] s_axil_rdata,
  output logic [1:0]  s_axil_rresp,
  output logic        s_axil_rvalid,
  input  logic        s_axil_rready,
  input  logic [31:0] s_axil_awaddr,
  input  logic        s_axil_awvalid,
  output logic        s_axil_awready,
  input  logic [31:0] s_axil_wdata,
  input  logic [3:0]  s_axil_wstrb,
  input  logic        s_axil_wvalid,
  output logic        s_axil_wready,
  output logic [1:0]  s_axil_bresp,
  output logic        s_axil_bvalid,
  input  logic        s_axil_bready
);

  localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;
  localparam logic [3:0]  LAT       = 4'(LATENCY);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  function automatic logic in_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return ({1'b0, off} < MEM_BYTES);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return AW'(off >> 2);
  endfunction

  logic [31:0] mem [MEM_WORDS];

  // Ready outputs stay low until the first clock edge after reset is released.
  logic live;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) live <= 1'b0;
    else         live <= 1'b1;
  end

  // ---------------- read engine ----------------
  r_state_t    r_state, r_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_src;
  logic        r_load, r_sample;
  logic        ar_hs, r_hs;

  assign s_axil_arready = live && (r_state == R_IDLE);
  assign s_axil_rvalid  = (r_state == R_RESP);
  assign ar_hs          = s_axil_arvalid && s_axil_arready;
  assign r_hs           = s_axil_rvalid && s_axil_rready;

  always_comb begin
    r_next   = r_state;
    r_load   = 1'b0;
    r_sample = 1'b0;
    r_src    = r_addr;
    case (r_state)
      R_IDLE: begin
        if (ar_hs) begin
          r_load = 1'b1;
          if (LAT == 4'd0) begin
            r_next   = R_RESP;
            r_sample = 1'b1;
            r_src    = s_axil_araddr;
          end else begin
            r_next = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_cnt == 4'd0) begin
          r_next   = R_RESP;
          r_sample = 1'b1;
        end
      end
      R_RESP: begin
        if (r_hs) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state      <= R_IDLE;
      r_cnt        <= 4'd0;
      r_addr       <= 32'd0;
      s_axil_rdata <= 32'd0;
      s_axil_rresp <= 2'b00;
    end else begin
      r_state <= r_next;
      if (r_load) begin
        r_addr <= s_axil_araddr;
        r_cnt  <= LAT;
      end else if (r_state == R_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Sampling uses the pre-write array contents when a write commits on the same edge.
      if (r_sample) begin
        if (in_range(r_src)) begin
          s_axil_rdata <= mem[word_idx(r_src)];
          s_axil_rresp <= 2'b00;
        end else begin
          s_axil_rdata <= 32'd0;
          s_axil_rresp <= 2'b10;
        end
      end
    end
  end

  // ---------------- write engine ----------------
  w_state_t    w_state, w_next;
  logic [3:0]  w_cnt;
  logic [31:0] w_addr, w_data;
  logic [3:0]  w_strb;
  logic        aw_done, w_done;
  logic        w_load, w_commit;
  logic        aw_hs, w_hs, b_hs;

  assign s_axil_awready = live && (w_state == W_IDLE) && !aw_done;
  assign s_axil_wready  = live && (w_state == W_IDLE) && !w_done;
  assign s_axil_bvalid  = (w_state == W_RESP);
  assign aw_hs          = s_axil_awvalid && s_axil_awready;
  assign w_hs           = s_axil_wvalid && s_axil_wready;
  assign b_hs           = s_axil_bvalid && s_axil_bready;

  always_comb begin
    w_next   = w_state;
    w_load   = 1'b0;
    w_commit = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_done && w_done) begin
          w_load = 1'b1;
          if (LAT == 4'd0) begin
            w_next   = W_RESP;
            w_commit = 1'b1;
          end else begin
            w_next = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        if (w_cnt == 4'd0) begin
          w_next   = W_RESP;
          w_commit = 1'b1;
        end
      end
      W_RESP: begin
        if (b_hs) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      w_state      <= W_IDLE;
      w_cnt        <= 4'd0;
      w_addr       <= 32'd0;
      w_data       <= 32'd0;
      w_strb       <= 4'd0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      s_axil_bresp <= 2'b00;
    end else begin
      w_state <= w_next;
      if (aw_hs) begin
        aw_done <= 1'b1;
        w_addr  <= s_axil_awaddr;
      end
      if (w_hs) begin
        w_done <= 1'b1;
        w_data <= s_axil_wdata;
        w_strb <= s_axil_wstrb;
      end
      if (b_hs) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (w_load) begin
        w_cnt <= LAT;
      end else if (w_state == W_WAIT && w_cnt != 4'd0) begin
        w_cnt <= w_cnt - 4'd1;
      end
      if (w_commit) s_axil_bresp <= in_range(w_addr) ? 2'b00 : 2'b10;
    end
  end

  // Array has no reset; a commit can only occur from a live write engine.
  always_ff @(posedge i_Clock) begin
    if (w_commit && in_range(w_addr)) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) mem[word_idx(w_addr)][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axil_memory_responder.sv
// Directed bench for axil_memory_responder: one instance with LATENCY=2 at a non-zero
// base, one with LATENCY=0 at base 0.
module tb_axil_memory_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] araddr [2];
  logic        arvalid[2];
  logic        arready[2];
  logic [31:0] rdata  [2];
  logic [1:0]  rresp  [2];
  logic        rvalid [2];
  logic        rready [2];
  logic [31:0] awaddr [2];
  logic        awvalid[2];
  logic        awready[2];
  logic [31:0] wdata  [2];
  logic [3:0]  wstrb  [2];
  logic        wvalid [2];
  logic        wready [2];
  logic [1:0]  bresp  [2];
  logic        bvalid [2];
  logic        bready [2];

  axil_memory_responder #(.BASE_ADDR(32'h4000_0000), .MEM_WORDS(256), .LATENCY(2)) dut (
    .i_Clock(clk), .i_Reset(rst),
    .s_axil_araddr(araddr[0]), .s_axil_arvalid(arvalid[0]), .s_axil_arready(arready[0]),
    .s_axil_rdata(rdata[0]), .s_axil_rresp(rresp[0]), .s_axil_rvalid(rvalid[0]),
    .s_axil_rready(rready[0]),
    .s_axil_awaddr(awaddr[0]), .s_axil_awvalid(awvalid[0]), .s_axil_awready(awready[0]),
    .s_axil_wdata(wdata[0]), .s_axil_wstrb(wstrb[0]), .s_axil_wvalid(wvalid[0]),
    .s_axil_wready(wready[0]),
    .s_axil_bresp(bresp[0]), .s_axil_bvalid(bvalid[0]), .s_axil_bready(bready[0])
  );

  axil_memory_responder #(.BASE_ADDR(32'h0000_0000), .MEM_WORDS(16), .LATENCY(0)) dut_l0 (
    .i_Clock(clk), .i_Reset(rst),
    .s_axil_araddr(araddr[1]), .s_axil_arvalid(arvalid[1]), .s_axil_arready(arready[1]),
    .s_axil_rdata(rdata[1]), .s_axil_rresp(rresp[1]), .s_axil_rvalid(rvalid[1]),
    .s_axil_rready(rready[1]),
    .s_axil_awaddr(awaddr[1]), .s_axil_awvalid(awvalid[1]), .s_axil_awready(awready[1]),
    .s_axil_wdata(wdata[1]), .s_axil_wstrb(wstrb[1]), .s_axil_wvalid(wvalid[1]),
    .s_axil_wready(wready[1]),
    .s_axil_bresp(bresp[1]), .s_axil_bvalid(bvalid[1]), .s_axil_bready(bready[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk({tag, "_arready"}, 32'(arready[d]), 0);
    chk({tag, "_awready"}, 32'(awready[d]), 0);
    chk({tag, "_wready"},  32'(wready[d]),  0);
    chk({tag, "_rvalid"},  32'(rvalid[d]),  0);
    chk({tag, "_bvalid"},  32'(bvalid[d]),  0);
    chk({tag, "_rdata"},   rdata[d],        0);
    chk({tag, "_rresp"},   32'(rresp[d]),   0);
    chk({tag, "_bresp"},   32'(bresp[d]),   0);
  endtask

  // Starts and ends on a falling edge. w_lead = cycles W is handshaken before AW.
  task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] data,
                          input logic [3:0] strb, input int w_lead,
                          input logic [1:0] exp_resp, input string tag);
    int n;
    chk({tag, "_awready0"}, 32'(awready[d]), 1);
    chk({tag, "_wready0"},  32'(wready[d]),  1);
    wdata[d] = data; wstrb[d] = strb; wvalid[d] = 1'b1; bready[d] = 1'b1;
    if (w_lead == 0) begin
      awaddr[d] = a; awvalid[d] = 1'b1;
    end
    @(posedge clk); #1;
    wvalid[d] = 1'b0;
    awvalid[d] = 1'b0;
    if (w_lead > 0) begin
      chk({tag, "_wready_drop"}, 32'(wready[d]), 0);
      chk({tag, "_awready_hold"}, 32'(awready[d]), 1);
      repeat (w_lead - 1) @(posedge clk);
      @(negedge clk);
      awaddr[d] = a; awvalid[d] = 1'b1;
      @(posedge clk); #1;
      awvalid[d] = 1'b0;
    end
    n = 0;
    while (!bvalid[d] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_bvalid"}, 32'(bvalid[d]), 1);
    chk({tag, "_bresp"},  32'(bresp[d]),  32'(exp_resp));
    @(posedge clk); #1;
    chk({tag, "_bvalid_clr"}, 32'(bvalid[d]), 0);
    @(negedge clk);
  endtask

  // exp_lat < 0 skips the latency comparison; stall = cycles rready is held low.
  task automatic do_read(input int d, input logic [31:0] a, input int exp_lat,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp,
                         input int stall, input string tag);
    int n;
    chk({tag, "_arready0"}, 32'(arready[d]), 1);
    araddr[d] = a; arvalid[d] = 1'b1; rready[d] = (stall == 0);
    @(posedge clk); #1;
    arvalid[d] = 1'b0;
    n = 0;
    while (!rvalid[d] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_rvalid"}, 32'(rvalid[d]), 1);
    if (exp_lat >= 0) chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_rdata"}, rdata[d], exp_data);
    chk({tag, "_rresp"}, 32'(rresp[d]), 32'(exp_resp));
    for (int i = 0; i < stall; i++) begin
      chk({tag, "_stall_rvalid"},  32'(rvalid[d]),  1);
      chk({tag, "_stall_rdata"},   rdata[d],        exp_data);
      chk({tag, "_stall_arready"}, 32'(arready[d]), 0);
      @(posedge clk); #1;
    end
    rready[d] = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_rvalid_clr"}, 32'(rvalid[d]), 0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      araddr[i] = '0; arvalid[i] = 1'b0; rready[i] = 1'b0;
      awaddr[i] = '0; awvalid[i] = 1'b0; wdata[i] = '0; wstrb[i] = '0;
      wvalid[i] = 1'b0; bready[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero(0, "rst_l2");
    chk_zero(1, "rst_l0");
    rst = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      chk("post_rst_arready", 32'(arready[d]), 1);
      chk("post_rst_awready", 32'(awready[d]), 1);
      chk("post_rst_wready",  32'(wready[d]),  1);
    end
    @(negedge clk);

    // Basic write then read, latency 2
    do_write(0, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 0, 2'b00, "w_basic");
    do_read (0, 32'h4000_0010, 3, 32'hDEAD_BEEF, 2'b00, 0, "r_basic");

    // W ahead of AW, partial strobes; read with low address bits set
    do_write(0, 32'h4000_0010, 32'h1122_3344, 4'b0101, 2, 2'b00, "w_lead");
    do_read (0, 32'h4000_0013, 3, 32'hDE22_BE44, 2'b00, 0, "r_merge");

    // Empty strobe: OKAY response, no change
    do_write(0, 32'h4000_0010, 32'hFFFF_FFFF, 4'h0, 1, 2'b00, "w_nostrb");
    do_read (0, 32'h4000_0010, 3, 32'hDE22_BE44, 2'b00, 0, "r_nostrb");

    // Range boundaries
    do_write(0, 32'h4000_0000, 32'h0102_0304, 4'hF, 0, 2'b00, "w_word0");
    do_write(0, 32'h4000_03FC, 32'h5A5A_0FF0, 4'hF, 0, 2'b00, "w_last");
    do_read (0, 32'h4000_03FC, 3, 32'h5A5A_0FF0, 2'b00, 0, "r_last");
    do_read (0, 32'h4000_0400, 3, 32'h0000_0000, 2'b10, 0, "r_oor_hi");
    do_read (0, 32'h4000_0000, 3, 32'h0102_0304, 2'b00, 0, "r_word0");
    do_read (0, 32'h3FFF_FFFC, 3, 32'h0000_0000, 2'b10, 0, "r_oor_lo");
    do_write(0, 32'h4000_0400, 32'hFFFF_FFFF, 4'hF, 0, 2'b10, "w_oor");
    do_read (0, 32'h4000_0000, 3, 32'h0102_0304, 2'b00, 0, "r_word0_kept");
    do_read (0, 32'h4000_03FC, 3, 32'h5A5A_0FF0, 2'b00, 0, "r_last_kept");

    // Read response stalled by the master
    do_read (0, 32'h4000_0010, 3, 32'hDE22_BE44, 2'b00, 5, "r_stall");

    // Reset while a write sits in W_WAIT
    do_write(0, 32'h4000_0020, 32'h1234_5678, 4'hF, 0, 2'b00, "w_pre");
    do_read (0, 32'h4000_0020, 3, 32'h1234_5678, 2'b00, 0, "r_pre");
    awaddr[0] = 32'h4000_0020; wdata[0] = 32'hAAAA_5555; wstrb[0] = 4'hF;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1; bready[0] = 1'b1;
    @(posedge clk); #1;
    awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    @(posedge clk); #1;
    chk("mid_bvalid", 32'(bvalid[0]), 0);
    #2 rst = 1'b1;
    #1;
    chk_zero(0, "rst_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero(0, "rst_held");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_arready", 32'(arready[0]), 1);
    chk("rel_awready", 32'(awready[0]), 1);
    chk("rel_wready",  32'(wready[0]),  1);
    @(negedge clk);
    do_read (0, 32'h4000_0020, 3, 32'h1234_5678, 2'b00, 0, "r_after_rst");
    chk("no_b_after_rst", 32'(bvalid[0]), 0);

    // Zero latency: read and write to one word resolving on the same edge
    do_write(1, 32'h0000_000C, 32'h0BAD_F00D, 4'hF, 0, 2'b00, "l0_w_old");
    do_read (1, 32'h0000_000C, -1, 32'h0BAD_F00D, 2'b00, 0, "l0_r_old");
    awaddr[1] = 32'h0000_000C; wdata[1] = 32'hC0FF_EE11; wstrb[1] = 4'hF;
    awvalid[1] = 1'b1; wvalid[1] = 1'b1; bready[1] = 1'b0;
    @(posedge clk); #1;
    awvalid[1] = 1'b0; wvalid[1] = 1'b0;
    chk("l0_latched_bvalid", 32'(bvalid[1]), 0);
    @(negedge clk);
    araddr[1] = 32'h0000_000C; arvalid[1] = 1'b1; rready[1] = 1'b0;
    @(posedge clk); #1;
    arvalid[1] = 1'b0;
    chk("l0_same_rvalid", 32'(rvalid[1]), 1);
    chk("l0_same_rdata",  rdata[1],       32'h0BAD_F00D);
    chk("l0_same_bvalid", 32'(bvalid[1]), 1);
    chk("l0_same_bresp",  32'(bresp[1]),  0);
    @(negedge clk);
    rready[1] = 1'b1; bready[1] = 1'b1;
    @(posedge clk); #1;
    chk("l0_same_rvalid_clr", 32'(rvalid[1]), 0);
    chk("l0_same_bvalid_clr", 32'(bvalid[1]), 0);
    @(negedge clk);
    do_read (1, 32'h0000_000C, -1, 32'hC0FF_EE11, 2'b00, 0, "l0_r_new");
    do_read (1, 32'h0000_0040, -1, 32'h0000_0000, 2'b10, 0, "l0_r_oor");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_memory_responder.md
AXIL_MEMORY_RESPONDER -- requirements
Module: axil_memory_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-002 SHALL have parameter MEM_WORDS, default 4096, number of 32-bit words; power of two.
REQ-003 SHALL have parameter LATENCY, default 2, extra wait cycles (0..15) before each response.
REQ-004 i_Clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 i_Reset  in  1  reset; asynchronous, active-high.
REQ-006 s_axil_araddr  in  32  read address.
REQ-007 s_axil_arvalid  in  1  read address valid.
REQ-008 s_axil_arready  out  1  read address accepted.
REQ-009 s_axil_rdata  out  32  read data.
REQ-010 s_axil_rresp  out  2  read response.
REQ-011 s_axil_rvalid  out  1  read data valid.
REQ-012 s_axil_rready  in  1  master accepts read data.
REQ-013 s_axil_awaddr  in  32  write address.
REQ-014 s_axil_awvalid  in  1  write address valid.
REQ-015 s_axil_awready  out  1  write address accepted.
REQ-016 s_axil_wdata  in  32  write data.
REQ-017 s_axil_wstrb  in  4  byte enables; bit n enables wdata[8n+7:8n].
REQ-018 s_axil_wvalid  in  1  write data valid.
REQ-019 s_axil_wready  out  1  write data accepted.
REQ-020 s_axil_bresp  out  2  write response.
REQ-021 s_axil_bvalid  out  1  write response valid.
REQ-022 s_axil_bready  in  1  master accepts write response.

Function
REQ-023 A handshake SHALL occur on a rising edge when valid and ready are both high.
REQ-024 Address decode: offset = addr - BASE_ADDR; in range iff offset < MEM_WORDS*4; word index = offset[log2(MEM_WORDS)+1:2]; addr[1:0] ignored.
REQ-025 Read FSM states: R_IDLE, R_WAIT, R_RESP. arready SHALL be 1 only in R_IDLE.
REQ-026 AR handshake in R_IDLE: latch address, load counter with LATENCY, go to R_WAIT (R_RESP directly when LATENCY=0).
REQ-027 R_WAIT: decrement counter each cycle; on counter=0 go to R_RESP.
REQ-028 Entering R_RESP: sample rdata from the array (in range, rresp=2'b00) or drive rdata=0, rresp=2'b10 (out of range).
REQ-029 R_RESP: rvalid=1; rdata and rresp held stable until R handshake, then R_IDLE.
REQ-030 Read latency from AR handshake to rvalid high SHALL be LATENCY+1 cycles.
REQ-031 Write FSM states: W_IDLE, W_WAIT, W_RESP. AW and W SHALL be accepted independently, in either order or the same cycle.
REQ-032 In W_IDLE: awready=1 until AW latched; wready=1 until W latched; each deasserts the cycle after its handshake.
REQ-033 When both are latched: load counter with LATENCY, go to W_WAIT (W_RESP directly when LATENCY=0).
REQ-034 On the edge entering W_RESP: write the enabled bytes (in range, bresp=2'b00) or write nothing, bresp=2'b10 (out of range); wstrb=0 writes nothing but responds 2'b00.
REQ-035 W_RESP: bvalid=1 until B handshake, then W_IDLE with both latches cleared.
REQ-036 Read and write FSMs SHALL run concurrently. A read sampling the same word on the same edge as a write SHALL return the pre-write value.
REQ-037 Held rvalid/bvalid with rready/bready low SHALL stall only that channel.
REQ-038 At most one read and one write SHALL be outstanding.

Reset
REQ-039 While i_Reset=1 and immediately on its assertion: arready=0, awready=0, wready=0, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0; both FSMs in idle; latches and counters cleared.
REQ-040 Reset mid-transaction SHALL discard the transaction with no response; a write not yet in W_RESP SHALL NOT modify the array.
REQ-041 The array SHALL NOT be cleared by reset.
REQ-042 On the first edge after deassertion: arready=1, awready=1, wready=1.

Verification
REQ-043 LATENCY=2: write 0xDEADBEEF, wstrb=4'hF, to BASE+0x10, then read it -> bresp=0; rvalid 3 cycles after AR handshake; rdata=0xDEADBEEF, rresp=0.
REQ-044 W presented 2 cycles before AW, wstrb=4'b0101, wdata=0x11223344, over word 0xDEADBEEF -> read returns 0xDE22BE44.
REQ-045 Read at BASE+MEM_WORDS*4 -> rresp=2'b10, rdata=0; write there -> bresp=2'b10, no word modified.
REQ-046 rready held low 5 cycles -> rvalid and rdata stable throughout, arready=0 until the handshake.
REQ-047 Assert i_Reset in W_WAIT of a write of 0xAAAA5555 over 0x12345678 -> outputs zero at once; a later read returns 0x12345678.
REQ-048 LATENCY=0: same-word read and write resolving on one edge -> read returns old value, a later read returns the new one.
